bram_delay_ctrl: RTL and testbench
==================================

Name: bram_delay_ctrl

Overview:
- Runtime-programmable sequencer for a single-port BRAM delay line built on sp_ram (always-write, read-before-write).
- Generates the RAM address and write enable, and tracks fill state so downstream logic gets a qualified dout_valid.
- Accepts new delay values mid-stream through a load/ack handshake.
- Replaces fixed-parameter delay instances wherever the delay must change at run time.

Parameters:
- ADDR_BITS, 10, RAM address width; RAM depth is 2**ADDR_BITS.
- LATENCY, 2, read latency of the attached sp_ram; must be 1 or 2.
- RESET_DELAY, 1024, delay in clocks loaded at reset; must lie in [LATENCY+1, 2**ADDR_BITS+LATENCY].

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- ce  in  1  clock enable; counters and FSM advance only when ce=1
- cfg_delay  in  ADDR_BITS+1  requested delay in clocks
- cfg_load  in  1  request to apply cfg_delay
- cfg_ack  out  1  one-cycle pulse when a load is accepted
- cfg_err  out  1  one-cycle pulse on a rejected load (only with DELAY_CFG_ERR_EN)
- ram_addr  out  ADDR_BITS  address to sp_ram
- ram_we  out  1  write enable to sp_ram
- dout_valid  out  1  RAM dout holds data written exactly D enabled clocks earlier
- cur_delay  out  ADDR_BITS+1  delay currently in force
- busy  out  1  high while in FILL

Behaviour:
- Reset (async, immediate):
  - ram_addr=0, ram_we=0, dout_valid=0, cfg_ack=0, cfg_err=0, busy=0.
  - cur_delay=RESET_DELAY, fill counter=0, state=IDLE.
- Effective wrap point W = cur_delay-LATENCY-1.
  - ram_addr increments by 1 on each ce=1 cycle in FILL/RUN.
  - ram_addr goes to 0 after reaching W.
- ram_we = 1 in FILL and RUN, 0 in IDLE. It is not gated by ce; the RAM write is qualified by ce at the top level.
- FSM, all transitions on clk edges with ce=1:
  - IDLE: first ce=1 cycle after reset -> FILL, with ram_addr=0 and fill counter=0.
  - FILL: busy=1. Fill counter increments per ce cycle. When it reaches cur_delay-1 -> RUN.
  - RUN: dout_valid=1. Stays in RUN until a load is accepted.
- Load handshake:
  - cfg_load is sampled on a ce=1 cycle. If accepted, the same edge:
    - sets cur_delay=cfg_delay and ram_addr=0;
    - clears fill counter and dout_valid;
    - enters FILL;
    - pulses cfg_ack for 1 clk.
  - cfg_load held high re-triggers on every ce cycle. The requester must drop it after cfg_ack.
- cfg_load while in FILL: accepted; restarts the fill with the new value.
- dout_valid timing: first asserts on the cycle in which the RAM output reflects the first write after the FILL start, i.e. exactly cur_delay ce-cycles after FILL entry.
- ce=0: all registers hold, including the FSM and the fill counter. cfg_ack/cfg_err are not issued.
- Minimum delay D=LATENCY+1: W=0, so ram_addr stays 0 and the RAM acts as a pure latency stage.
- Maximum delay D=2**ADDR_BITS+LATENCY: W=2**ADDR_BITS-1, full natural wrap.
- Widths: all comparisons use ADDR_BITS+1 bits; no truncation of cur_delay.

Optional Feature:
- DELAY_CFG_ERR_EN
  - Defined: cfg_delay outside [LATENCY+1, 2**ADDR_BITS+LATENCY] is rejected. cfg_err pulses for 1 clk, there is no cfg_ack, and state, cur_delay and ram_addr are unchanged.
  - Undefined: out-of-range values are clamped to the nearest bound and accepted with cfg_ack. cfg_err is tied to 0.

Test Plan:
- Reset, ce=1 constant, ADDR_BITS=4, LATENCY=2, RESET_DELAY=10:
  - ram_addr cycles 0..7.
  - busy high for 10 cycles, then dout_valid=1.
  - a ramp on din appears at dout exactly 10 cycles later.
- In RUN, pulse cfg_load with cfg_delay=5:
  - cfg_ack next edge, ram_addr=0, dout_valid=0.
  - ram_addr wraps at 2.
  - dout_valid returns after 5 cycles; ramp delayed by 5.
- Assert rst mid-FILL: all outputs go to reset values immediately, without waiting for a clk edge; after release, FILL restarts from ram_addr=0.
- Toggle ce with a 50% pattern: delay is measured in ce cycles; with D=10, dout_valid asserts after 10 ce-high cycles (20 clocks).
- cfg_delay=3 (minimum), then cfg_delay=18 (maximum): ram_addr stays 0, then cycles 0..15. Data is delayed 3 and 18 cycles respectively.
- cfg_delay=2:
  - With DELAY_CFG_ERR_EN: cfg_err pulse, cur_delay unchanged.
  - Without DELAY_CFG_ERR_EN: cur_delay=3, cfg_ack pulse.

Source files
------------

// File: rtl/bram_delay_ctrl.sv
// ---------------------------------------------------------------------------
// bram_delay_ctrl
//
// Run-time programmable sequencer for a single-port BRAM delay line built on
// sp_ram (always-write, read-before-write). It walks the RAM address over a
// window sized from the delay in force, drives the write enable, and tracks
// how much of the window has been filled so downstream logic sees a qualified
// dout_valid. New delay values are accepted mid-stream via cfg_load/cfg_ack.
//
// Optional feature macro: DELAY_CFG_ERR_EN
//   defined   : out-of-range cfg_delay is rejected with a cfg_err pulse.
//   undefined : out-of-range cfg_delay is clamped and accepted; cfg_err = 0.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   ce         in   clock enable; counters and FSM advance only when ce=1
//   cfg_delay  in   [ADDR_BITS:0] requested delay in clocks
//   cfg_load   in   request to apply cfg_delay (sampled on ce=1 cycles)
//   cfg_ack    out  one-cycle pulse when a load is accepted
//   cfg_err    out  one-cycle pulse when a load is rejected
//   ram_addr   out  [ADDR_BITS-1:0] address to sp_ram
//   ram_we     out  write enable to sp_ram (qualified by ce at top level)
//   dout_valid out  RAM dout holds data written exactly cur_delay ce-cycles ago
//   cur_delay  out  [ADDR_BITS:0] delay currently in force
//   busy       out  high while the delay line is filling
// ---------------------------------------------------------------------------
module bram_delay_ctrl #(
  parameter int ADDR_BITS   = 10,
  parameter int LATENCY     = 2,
  parameter int RESET_DELAY = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [ADDR_BITS:0]   cfg_delay,
  input  logic                 cfg_load,
  output logic                 cfg_ack,
  output logic                 cfg_err,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_we,
  output logic                 dout_valid,
  output logic [ADDR_BITS:0]   cur_delay,
  output logic                 busy
);

  localparam int DW = ADDR_BITS + 1;

  // Legal delay range: the RAM read latency is the shortest possible delay
  // plus one write slot; the longest uses every RAM word plus the latency.
  localparam logic [ADDR_BITS:0] MIN_DELAY = DW'(LATENCY + 1);
  localparam logic [ADDR_BITS:0] MAX_DELAY = DW'((2 ** ADDR_BITS) + LATENCY);
  localparam logic [ADDR_BITS:0] RST_DELAY = DW'(RESET_DELAY);
  localparam logic [ADDR_BITS:0] ONE       = DW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS:0]   cur_delay_q, cur_delay_d;
  logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_BITS:0]   fill_cnt_q, fill_cnt_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;

  logic [ADDR_BITS:0]   wrap_pt;
  logic [ADDR_BITS-1:0] addr_next;
  logic                 cfg_low, cfg_high;
  logic                 load_ok, load_bad;
  logic [ADDR_BITS:0]   new_delay;

  // The address window is shortened by the RAM latency so that the word
  // written at a given slot comes back out exactly cur_delay cycles later.
  assign wrap_pt   = cur_delay_q - MIN_DELAY;
  assign addr_next = ({1'b0, ram_addr_q} == wrap_pt) ? '0 : ram_addr_q + 1'b1;

  assign cfg_low  = (cfg_delay < MIN_DELAY);
  assign cfg_high = (cfg_delay > MAX_DELAY);

  // Decide whether a load request is taken and what delay it installs.
`ifdef DELAY_CFG_ERR_EN
  assign load_ok   = cfg_load & ~(cfg_low | cfg_high);
  assign load_bad  = cfg_load &  (cfg_low | cfg_high);
  assign new_delay = cfg_delay;
`else
  assign load_ok   = cfg_load;
  assign load_bad  = 1'b0;
  assign new_delay = cfg_low ? MIN_DELAY : (cfg_high ? MAX_DELAY : cfg_delay);
`endif

  // State register: every piece of sequencer state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_delay_q <= RST_DELAY;
      ram_addr_q  <= '0;
      fill_cnt_q  <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_delay_q <= cur_delay_d;
      ram_addr_q  <= ram_addr_d;
      fill_cnt_q  <= fill_cnt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic. Nothing moves without ce; the ack/err pulses default to
  // zero every clock so they last exactly one clk. An accepted load overrides
  // whatever the FSM would otherwise do and restarts the fill from address 0.
  // A rejected load is simply ignored and sequencing carries on.
  always_comb begin
    state_d     = state_q;
    cur_delay_d = cur_delay_q;
    ram_addr_d  = ram_addr_q;
    fill_cnt_d  = fill_cnt_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    if (ce) begin
      if (load_ok) begin
        state_d     = FILL;
        cur_delay_d = new_delay;
        ram_addr_d  = '0;
        fill_cnt_d  = '0;
        ack_d       = 1'b1;
      end else begin
        err_d = load_bad;
        case (state_q)
          IDLE: begin
            state_d    = FILL;
            ram_addr_d = '0;
            fill_cnt_d = '0;
          end
          FILL: begin
            ram_addr_d = addr_next;
            if (fill_cnt_q == (cur_delay_q - ONE)) begin
              state_d = RUN;
            end else begin
              fill_cnt_d = fill_cnt_q + ONE;
            end
          end
          RUN: begin
            ram_addr_d = addr_next;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  // Outputs decoded from registered state only, so they are glitch-free and
  // fall straight to their reset values when rst asserts.
  always_comb begin
    ram_we     = 1'b0;
    busy       = 1'b0;
    dout_valid = 1'b0;
    case (state_q)
      FILL: begin
        ram_we = 1'b1;
        busy   = 1'b1;
      end
      RUN: begin
        ram_we     = 1'b1;
        dout_valid = 1'b1;
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
  end

  assign ram_addr  = ram_addr_q;
  assign cur_delay = cur_delay_q;
  assign cfg_ack   = ack_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_bram_delay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bram_delay_ctrl
//
// Directed bench for bram_delay_ctrl with ADDR_BITS=4, LATENCY=2,
// RESET_DELAY=10. A small behavioural sp_ram (read-before-write, two-stage
// read pipeline, all advancing on ce) is attached, and a ramp is written into
// it so the delay through the RAM can be checked as dout == ramp - D.
// Expected values for DELAY_CFG_ERR_EN builds follow the same macro.
// ---------------------------------------------------------------------------
module tb_bram_delay_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic [4:0]  cfg_delay = 5'd0;
  logic        cfg_load = 1'b0;
  logic        cfg_ack;
  logic        cfg_err;
  logic [3:0]  ram_addr;
  logic        ram_we;
  logic        dout_valid;
  logic [4:0]  cur_delay;
  logic        busy;

  logic [15:0] ramp = 16'd0;
  logic [15:0] mem [0:15];
  logic [15:0] rd1 = 16'd0;
  logic [15:0] dout_m = 16'd0;

  int checks = 0;
  int errors = 0;

  bram_delay_ctrl #(
    .ADDR_BITS  (4),
    .LATENCY    (2),
    .RESET_DELAY(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .cfg_delay (cfg_delay),
    .cfg_load  (cfg_load),
    .cfg_ack   (cfg_ack),
    .cfg_err   (cfg_err),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .dout_valid(dout_valid),
    .cur_delay (cur_delay),
    .busy      (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural sp_ram with a ramp source: read-before-write, latency 2.
  always @(posedge clk) begin
    if (ce) begin
      ramp   <= ramp + 16'd1;
      rd1    <= mem[ram_addr];
      dout_m <= rd1;
      if (ram_we) mem[ram_addr] <= ramp;
    end
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a load request for one clock edge.
  task automatic applyStimulus(input logic [4:0] d);
    cfg_delay = d;
    cfg_load  = 1'b1;
    tick();
    cfg_load  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ce  = 1'b1;
    repeat (2) tick();
    checks++; if (ram_addr !== 4'd0) begin errors++; $display("[TB] FAIL reset_addr got %0d want 0", ram_addr); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", ram_we); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", dout_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ackerr got %b%b want 00", cfg_ack, cfg_err); end
    checks++; if (cur_delay !== 5'd10) begin errors++; $display("[TB] FAIL reset_delay got %0d want 10", cur_delay); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_run();
    tick();
    checks++; if (busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'd0) begin errors++; $display("[TB] FAIL fill_entry got busy=%b we=%b addr=%0d want 1 1 0", busy, ram_we, ram_addr); end
    for (int k = 2; k <= 10; k++) begin
      tick();
      checks++; if (ram_addr !== 4'((k - 1) % 8)) begin errors++; $display("[TB] FAIL fill_addr got %0d want %0d", ram_addr, (k - 1) % 8); end
      checks++; if (busy !== 1'b1 || dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL fill_flags got busy=%b valid=%b want 1 0", busy, dout_valid); end
    end
    tick();
    checks++; if (dout_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL run_entry got valid=%b busy=%b want 1 0", dout_valid, busy); end
    checks++; if (ram_addr !== 4'd2) begin errors++; $display("[TB] FAIL run_addr got %0d want 2", ram_addr); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (dout_m !== 16'(ramp - 16'd10)) begin errors++; $display("[TB] FAIL ramp10 got %0d want %0d", dout_m, 16'(ramp - 16'd10)); end
      tick();
    end
  endtask

  task automatic test_load();
    applyStimulus(5'd5);
    checks++; if (cfg_ack !== 1'b1) begin errors++; $display("[TB] FAIL load_ack got %b want 1", cfg_ack); end
    checks++; if (ram_addr !== 4'd0 || dout_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL load_restart got addr=%0d valid=%b busy=%b want 0 0 1", ram_addr, dout_valid, busy); end
    checks++; if (cur_delay !== 5'd5) begin errors++; $display("[TB] FAIL load_delay got %0d want 5", cur_delay); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (cfg_ack !== 1'b0) begin errors++; $display("[TB] FAIL ack_pulse got %b want 0", cfg_ack); end
      checks++; if (ram_addr !== 4'(k % 3) || dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL d5_fill got addr=%0d valid=%b want %0d 0", ram_addr, dout_valid, k % 3); end
    end
    tick();
    checks++; if (dout_valid !== 1'b1 || ram_addr !== 4'd2) begin errors++; $display("[TB] FAIL d5_run got valid=%b addr=%0d want 1 2", dout_valid, ram_addr); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (dout_m !== 16'(ramp - 16'd5)) begin errors++; $display("[TB] FAIL ramp5 got %0d want %0d", dout_m, 16'(ramp - 16'd5)); end
      tick();
    end
  endtask

  task automatic test_reset_mid_fill();
    applyStimulus(5'd7);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (ram_addr !== 4'd0 || ram_we !== 1'b0) begin errors++; $display("[TB] FAIL async_addr_we got addr=%0d we=%b want 0 0", ram_addr, ram_we); end
    checks++; if (busy !== 1'b0 || dout_valid !== 1'b0 || cfg_ack !== 1'b0) begin errors++; $display("[TB] FAIL async_flags got busy=%b valid=%b ack=%b want 0 0 0", busy, dout_valid, cfg_ack); end
    checks++; if (cur_delay !== 5'd10) begin errors++; $display("[TB] FAIL async_delay got %0d want 10", cur_delay); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b1 || ram_addr !== 4'd0) begin errors++; $display("[TB] FAIL refill_entry got busy=%b addr=%0d want 1 0", busy, ram_addr); end
    tick();
    checks++; if (ram_addr !== 4'd1) begin errors++; $display("[TB] FAIL refill_addr got %0d want 1", ram_addr); end
  endtask

  task automatic test_ce_toggle();
    applyStimulus(5'd10);
    for (int j = 1; j <= 10; j++) begin
      ce = 1'b0;
      tick();
      checks++; if (dout_valid !== 1'b0 || cfg_ack !== 1'b0 || ram_addr !== 4'((j - 1) % 8)) begin errors++; $display("[TB] FAIL ce_low got valid=%b ack=%b addr=%0d want 0 0 %0d", dout_valid, cfg_ack, ram_addr, (j - 1) % 8); end
      ce = 1'b1;
      tick();
      checks++; if (dout_valid !== (j == 10) || ram_addr !== 4'(j % 8)) begin errors++; $display("[TB] FAIL ce_high got valid=%b addr=%0d want %b %0d", dout_valid, ram_addr, (j == 10), j % 8); end
    end
    checks++; if (dout_m !== 16'(ramp - 16'd10)) begin errors++; $display("[TB] FAIL ce_ramp got %0d want %0d", dout_m, 16'(ramp - 16'd10)); end
    ce        = 1'b0;
    cfg_delay = 5'd4;
    cfg_load  = 1'b1;
    tick();
    cfg_load  = 1'b0;
    checks++; if (cfg_ack !== 1'b0 || cur_delay !== 5'd10 || dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL ce_load_blocked got ack=%b delay=%0d valid=%b want 0 10 1", cfg_ack, cur_delay, dout_valid); end
    ce = 1'b1;
    tick();
  endtask

  task automatic test_min_max();
    applyStimulus(5'd3);
    checks++; if (cfg_ack !== 1'b1 || cur_delay !== 5'd3 || ram_addr !== 4'd0) begin errors++; $display("[TB] FAIL min_load got ack=%b delay=%0d addr=%0d want 1 3 0", cfg_ack, cur_delay, ram_addr); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++; if (ram_addr !== 4'd0 || dout_valid !== (k >= 3)) begin errors++; $display("[TB] FAIL min_seq got addr=%0d valid=%b want 0 %b", ram_addr, dout_valid, (k >= 3)); end
      if (k >= 3) begin
        checks++; if (dout_m !== 16'(ramp - 16'd3)) begin errors++; $display("[TB] FAIL ramp3 got %0d want %0d", dout_m, 16'(ramp - 16'd3)); end
      end
    end
    applyStimulus(5'd18);
    checks++; if (cfg_ack !== 1'b1 || cur_delay !== 5'd18 || ram_addr !== 4'd0) begin errors++; $display("[TB] FAIL max_load got ack=%b delay=%0d addr=%0d want 1 18 0", cfg_ack, cur_delay, ram_addr); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++; if (ram_addr !== 4'(k % 16) || dout_valid !== (k >= 18)) begin errors++; $display("[TB] FAIL max_seq got addr=%0d valid=%b want %0d %b", ram_addr, dout_valid, k % 16, (k >= 18)); end
      if (k >= 18) begin
        checks++; if (dout_m !== 16'(ramp - 16'd18)) begin errors++; $display("[TB] FAIL ramp18 got %0d want %0d", dout_m, 16'(ramp - 16'd18)); end
      end
    end
  endtask

  task automatic test_clamp();
    applyStimulus(5'd2);
`ifdef DELAY_CFG_ERR_EN
    checks++; if (cfg_err !== 1'b1 || cfg_ack !== 1'b0 || cur_delay !== 5'd18) begin errors++; $display("[TB] FAIL low_reject got err=%b ack=%b delay=%0d want 1 0 18", cfg_err, cfg_ack, cur_delay); end
`else
    checks++; if (cfg_ack !== 1'b1 || cfg_err !== 1'b0 || cur_delay !== 5'd3) begin errors++; $display("[TB] FAIL low_clamp got ack=%b err=%b delay=%0d want 1 0 3", cfg_ack, cfg_err, cur_delay); end
`endif
    tick();
    checks++; if (cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL clamp_pulse got ack=%b err=%b want 0 0", cfg_ack, cfg_err); end
    applyStimulus(5'd31);
`ifdef DELAY_CFG_ERR_EN
    checks++; if (cfg_err !== 1'b1 || cfg_ack !== 1'b0 || cur_delay !== 5'd18) begin errors++; $display("[TB] FAIL high_reject got err=%b ack=%b delay=%0d want 1 0 18", cfg_err, cfg_ack, cur_delay); end
`else
    checks++; if (cfg_ack !== 1'b1 || cfg_err !== 1'b0 || cur_delay !== 5'd18) begin errors++; $display("[TB] FAIL high_clamp got ack=%b err=%b delay=%0d want 1 0 18", cfg_ack, cfg_err, cur_delay); end
`endif
    applyStimulus(5'd0);
`ifdef DELAY_CFG_ERR_EN
    checks++; if (cfg_err !== 1'b1 || cur_delay !== 5'd18) begin errors++; $display("[TB] FAIL zero_reject got err=%b delay=%0d want 1 18", cfg_err, cur_delay); end
`else
    checks++; if (cfg_ack !== 1'b1 || cur_delay !== 5'd3) begin errors++; $display("[TB] FAIL zero_clamp got ack=%b delay=%0d want 1 3", cfg_ack, cur_delay); end
`endif
    applyStimulus(5'd12);
    checks++; if (cfg_ack !== 1'b1 || cfg_err !== 1'b0 || cur_delay !== 5'd12 || ram_addr !== 4'd0) begin errors++; $display("[TB] FAIL inrange_load got ack=%b err=%b delay=%0d addr=%0d want 1 0 12 0", cfg_ack, cfg_err, cur_delay, ram_addr); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_fill_run();
    test_load();
    test_reset_mid_fill();
    test_ce_toggle();
    test_min_max();
    test_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
